tlp_hdr_encoder: RTL

- Transmit-side TLP builder. Takes a request descriptor and, for write/data kinds, a 32-bit payload stream.
- Drives a DW-serial TLP stream (header first, then payload) with sop/eop framing.
- Fmt/Type encoding matches what the receive-side fmt/type decoder expects. The block sits between the transaction layer request scheduler and the link-layer TX framer.

---
 rtl/tlp_hdr_encoder_if.sv | 55 +++++
 rtl/tlp_hdr_encoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tlp_hdr_encoder_if.sv
// tlp_hdr_encoder_if
//   Bundles the three streams around the TLP header encoder:
//     req_*  : request descriptor handshake (scheduler -> encoder)
//     pay_*  : 32-bit payload stream for data-carrying kinds (scheduler -> encoder)
//     tx_*   : DW-serial TLP stream with sop/eop framing (encoder -> TX framer)
//     err_unsupported : pulse when an unsupported kind is accepted and dropped
//   modport slave  : the encoder's view
//   modport master : the view of whatever drives and consumes the encoder
interface tlp_hdr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_kind;
  logic [63:0] req_addr;
  logic [9:0]  req_len;
  logic [15:0] req_id;
  logic [7:0]  req_tag;
  logic [7:0]  req_be;
  logic [2:0]  req_sub;
  logic [11:0] req_cpl_bc;
  logic [15:0] req_cpl_rid;

  logic        pay_valid;
  logic        pay_ready;
  logic [31:0] pay_data;

  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        tx_sop;
  logic        tx_eop;

  logic        err_unsupported;

  modport slave (
    input  req_valid, req_kind, req_addr, req_len, req_id, req_tag, req_be,
           req_sub, req_cpl_bc, req_cpl_rid,
    output req_ready,
    input  pay_valid, pay_data,
    output pay_ready,
    input  tx_ready,
    output tx_valid, tx_data, tx_sop, tx_eop,
    output err_unsupported
  );

  modport master (
    output req_valid, req_kind, req_addr, req_len, req_id, req_tag, req_be,
           req_sub, req_cpl_bc, req_cpl_rid,
    input  req_ready,
    output pay_valid, pay_data,
    input  pay_ready,
    output tx_ready,
    input  tx_valid, tx_data, tx_sop, tx_eop,
    input  err_unsupported
  );
endinterface

// File: rtl/tlp_hdr_encoder.sv
// tlp_hdr_encoder
//   Transmit-side TLP builder. Accepts a request descriptor, builds a 3DW or
//   4DW header and emits it DW-serially, followed (for data kinds) by the
//   payload stream passed straight through with zero latency.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : tlp_hdr_encoder_if.slave (req_*, pay_*, tx_*, err_unsupported)
//   Parameters:
//     FORCE_4DW  : 1 forces a 4DW header on every memory request
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a descriptor; req_ready=1
//   HDR   | emitting latched header DWs 0..hdr_cnt-1
//   DATA  | passing payload through until dat_cnt reaches zero
module tlp_hdr_encoder #(
  parameter bit FORCE_4DW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  tlp_hdr_encoder_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]  state;
  logic [31:0] hdr [4];
  logic [2:0]  hdr_cnt;
  logic [10:0] dat_cnt;
  logic [1:0]  idx;
  logic        has_data_q;
  logic        err_q;

  // descriptor decode
  logic [2:0]  fmt;
  logic [4:0]  typ;
  logic        has_data;
  logic        is_4dw;
  logic        is_cpl;
  logic        len_one;
  logic        supported;
  logic        mem_4dw;
  logic [9:0]  len_f;
  logic [31:0] dw0, dw1, dw2, dw3;
  logic [10:0] dat_load;

  assign mem_4dw = (bus.req_addr[63:32] != 32'h0) || FORCE_4DW;

  always_comb begin
    typ       = 5'b00000;
    has_data  = 1'b0;
    is_4dw    = 1'b0;
    is_cpl    = 1'b0;
    len_one   = 1'b0;
    supported = 1'b1;
    case (bus.req_kind)
      4'd0:  begin typ = 5'b00000; is_4dw = mem_4dw; end
      4'd1:  begin typ = 5'b00001; is_4dw = mem_4dw; end
      4'd2:  begin typ = 5'b00000; is_4dw = mem_4dw; has_data = 1'b1; end
      4'd3:  begin typ = 5'b00010; len_one = 1'b1; end
      4'd4:  begin typ = 5'b00010; len_one = 1'b1; has_data = 1'b1; end
      4'd5:  begin typ = 5'b00100; len_one = 1'b1; end
      4'd6:  begin typ = 5'b00100; len_one = 1'b1; has_data = 1'b1; end
      4'd7:  begin typ = {2'b10, bus.req_sub}; is_4dw = 1'b1; end
      4'd8:  begin typ = {2'b10, bus.req_sub}; is_4dw = 1'b1; has_data = 1'b1; end
      4'd9:  begin typ = 5'b01010; is_cpl = 1'b1; end
      4'd10: begin typ = 5'b01010; is_cpl = 1'b1; has_data = 1'b1; end
      default: supported = 1'b0;
    endcase

    // fmt[1] flags a data payload, fmt[0] a 4DW header
    fmt   = {1'b0, has_data, is_4dw};
    len_f = len_one ? 10'd1 : bus.req_len;

    dw0 = {fmt, typ, 8'h00, 6'b000000, len_f};
    if (is_cpl)
      dw1 = {bus.req_id, bus.req_sub, 1'b0, bus.req_cpl_bc};
    else
      dw1 = {bus.req_id, bus.req_tag, bus.req_be};

    if (is_cpl) begin
      dw2 = {bus.req_cpl_rid, bus.req_tag, 1'b0, bus.req_addr[6:0]};
      dw3 = 32'h0;
    end else if (is_4dw) begin
      dw2 = bus.req_addr[63:32];
      dw3 = {bus.req_addr[31:2], 2'b00};
    end else begin
      dw2 = {bus.req_addr[31:2], 2'b00};
      dw3 = 32'h0;
    end

    // a zero length field encodes the maximum of 1024 DW
    dat_load = (len_f == 10'd0) ? 11'd1024 : {1'b0, len_f};
  end

  logic hdr_last;
  assign hdr_last = ({1'b0, idx} == (hdr_cnt - 3'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      for (int i = 0; i < 4; i++) hdr[i] <= 32'h0;
      hdr_cnt    <= 3'd3;
      dat_cnt    <= 11'd0;
      idx        <= 2'd0;
      has_data_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (!supported) begin
              err_q <= 1'b1;
            end else begin
              hdr[0]     <= dw0;
              hdr[1]     <= dw1;
              hdr[2]     <= dw2;
              hdr[3]     <= dw3;
              hdr_cnt    <= is_4dw ? 3'd4 : 3'd3;
              dat_cnt    <= dat_load;
              has_data_q <= has_data;
              idx        <= 2'd0;
              state      <= HDR;
            end
          end
        end
        HDR: begin
          if (bus.tx_ready) begin
            if (hdr_last)
              state <= has_data_q ? DATA : IDLE;
            else
              idx <= idx + 2'd1;
          end
        end
        DATA: begin
          if (bus.pay_valid && bus.tx_ready) begin
            dat_cnt <= dat_cnt - 11'd1;
            if (dat_cnt == 11'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rst_n gating keeps req_ready low for the whole reset window even though
  // the state register already reads IDLE.
  assign bus.req_ready       = rst_n && (state == IDLE);
  assign bus.err_unsupported = err_q;

  always_comb begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 32'h0;
    bus.tx_sop    = 1'b0;
    bus.tx_eop    = 1'b0;
    bus.pay_ready = 1'b0;
    case (state)
      HDR: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = hdr[idx];
        bus.tx_sop   = (idx == 2'd0);
        bus.tx_eop   = hdr_last && !has_data_q;
      end
      DATA: begin
        bus.tx_valid  = bus.pay_valid;
        bus.tx_data   = bus.pay_data;
        bus.tx_eop    = (dat_cnt == 11'd1);
        bus.pay_ready = bus.tx_ready;
      end
      default: ;
    endcase
  end

endmodule
